// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - multi-cycle multiply/divide sequencer owning the HI/LO registers
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdu_op,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic        md_use,
  output logic        busy,
  output logic        done,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       op_q;
  logic [31:0]      a_q;
  logic [31:0]      b_q;

  logic        is_arith_start;
  logic [63:0] prod;
  logic        div_signed;
  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] div_den;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;
  logic        div_by_zero;
  logic        res_wr;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  assign busy = (state == S_BUSY);

  // ID must hold an MDU user while an op runs or is being launched this cycle
  always_comb begin
    is_arith_start = start && (mdu_op == OP_MULT || mdu_op == OP_MULTU ||
                               mdu_op == OP_DIV  || mdu_op == OP_DIVU);
    stall = md_use && (busy || is_arith_start);
  end

  // Product from latched operands; the low 64 bits of a sign-extended multiply
  // equal the signed product, so one multiplier serves both mult and multu
  always_comb begin
    prod = 64'd0;
    if (op_q == OP_MULT) begin
      prod = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    end else begin
      prod = {32'd0, a_q} * {32'd0, b_q};
    end
  end

  // Divide on magnitudes then restore signs: quotient truncates toward zero,
  // remainder follows the dividend; 0x80000000 / -1 wraps to 0x80000000 naturally
  always_comb begin
    div_signed  = (op_q == OP_DIV);
    neg_a       = div_signed && a_q[31];
    neg_b       = div_signed && b_q[31];
    mag_a       = neg_a ? (32'd0 - a_q) : a_q;
    mag_b       = neg_b ? (32'd0 - b_q) : b_q;
    div_by_zero = (b_q == 32'd0);
    div_den     = div_by_zero ? 32'd1 : mag_b;
    q_mag       = mag_a / div_den;
    r_mag       = mag_a % div_den;
    quot        = (neg_a ^ neg_b) ? (32'd0 - q_mag) : q_mag;
    rem         = neg_a ? (32'd0 - r_mag) : r_mag;
  end

  // Select what lands in HI/LO when the sequence completes
  always_comb begin
    res_wr = 1'b0;
    res_hi = 32'd0;
    res_lo = 32'd0;
    case (op_q)
      OP_MULT, OP_MULTU: begin
        res_wr = 1'b1;
        res_hi = prod[63:32];
        res_lo = prod[31:0];
      end
      OP_DIV, OP_DIVU: begin
        res_wr = !div_by_zero;
        res_hi = rem;
        res_lo = quot;
      end
      default: begin
        res_wr = 1'b0;
      end
    endcase
  end

  // Sequencer: launch in IDLE, count down in BUSY, commit HI/LO on the last edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      op_q  <= OP_NONE;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      done  <= 1'b0;
      hi    <= 32'd0;
      lo    <= 32'd0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            case (mdu_op)
              OP_MULT, OP_MULTU: begin
                op_q  <= mdu_op;
                a_q   <= in_a;
                b_q   <= in_b;
                cnt   <= CNT_W'(MULT_CYCLES);
                state <= S_BUSY;
              end
              OP_DIV, OP_DIVU: begin
                op_q  <= mdu_op;
                a_q   <= in_a;
                b_q   <= in_b;
                cnt   <= CNT_W'(DIV_CYCLES);
                state <= S_BUSY;
              end
              OP_MTHI: hi <= in_a;
              OP_MTLO: lo <= in_a;
              default: begin
              end
            endcase
          end
        end
        S_BUSY: begin
          if (cnt == CNT_W'(1)) begin
            state <= S_IDLE;
            cnt   <= '0;
            done  <= 1'b1;
            if (res_wr) begin
              hi <= res_hi;
              lo <= res_lo;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - directed self-checking bench for mdu_ctrl
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  mdu_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        md_use;
  logic        busy;
  logic        done;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .mdu_op (mdu_op),
    .in_a   (in_a),
    .in_b   (in_b),
    .md_use (md_use),
    .busy   (busy),
    .done   (done),
    .stall  (stall),
    .hi     (hi),
    .lo     (lo)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one op, scrambles operands during BUSY, and stops in the cycle after busy falls
  task automatic issue_and_wait(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                output int nbusy, output logic done_after);
    start  = 1'b1;
    mdu_op = op;
    in_a   = a;
    in_b   = b;
    step();
    start  = 1'b0;
    mdu_op = 3'd0;
    in_a   = ~a;
    in_b   = b + 32'd3;
    nbusy  = 0;
    while (busy === 1'b1 && nbusy < 64) begin
      nbusy++;
      step();
    end
    done_after = done;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; mdu_op = 3'd0; in_a = 32'd0; in_b = 32'd0; md_use = 1'b0;
    step(); step();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %h want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %h want 0", done); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %h want 0", stall); end
    n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi got %h want 0", hi); end
    n_checks++; if (lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo got %h want 0", lo); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_mult();
    int nb; logic d;
    issue_and_wait(3'd1, 32'hFFFFFFFD, 32'd5, nb, d);
    n_checks++; if (nb != 5) begin n_fail++; $display("FAIL mult_busy_cycles got %0d want 5", nb); end
    n_checks++; if (d !== 1'b1) begin n_fail++; $display("FAIL mult_done got %h want 1", d); end
    n_checks++; if (hi !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mult_hi got %h want ffffffff", hi); end
    n_checks++; if (lo !== 32'hFFFFFFF1) begin n_fail++; $display("FAIL mult_lo got %h want fffffff1", lo); end
    step();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL mult_done_width got %h want 0", done); end
    n_checks++; if (hi !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mult_hi_stable got %h want ffffffff", hi); end
  endtask

  task automatic test_multu();
    int nb; logic d;
    issue_and_wait(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, nb, d);
    n_checks++; if (nb != 5) begin n_fail++; $display("FAIL multu_busy_cycles got %0d want 5", nb); end
    n_checks++; if (hi !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL multu_hi got %h want fffffffe", hi); end
    n_checks++; if (lo !== 32'h00000001) begin n_fail++; $display("FAIL multu_lo got %h want 00000001", lo); end
    step();
  endtask

  task automatic test_div();
    int nb; logic d;
    issue_and_wait(3'd3, 32'hFFFFFFF9, 32'd2, nb, d);
    n_checks++; if (nb != 10) begin n_fail++; $display("FAIL div_busy_cycles got %0d want 10", nb); end
    n_checks++; if (d !== 1'b1) begin n_fail++; $display("FAIL div_done got %h want 1", d); end
    n_checks++; if (lo !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div_lo got %h want fffffffd", lo); end
    n_checks++; if (hi !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div_hi got %h want ffffffff", hi); end
    step();
    issue_and_wait(3'd4, 32'hFFFFFFF9, 32'd2, nb, d);
    n_checks++; if (lo !== 32'h7FFFFFFC) begin n_fail++; $display("FAIL divu_lo got %h want 7ffffffc", lo); end
    n_checks++; if (hi !== 32'h00000001) begin n_fail++; $display("FAIL divu_hi got %h want 00000001", hi); end
    step();
    issue_and_wait(3'd3, 32'h80000000, 32'hFFFFFFFF, nb, d);
    n_checks++; if (lo !== 32'h80000000) begin n_fail++; $display("FAIL div_ovf_lo got %h want 80000000", lo); end
    n_checks++; if (hi !== 32'h00000000) begin n_fail++; $display("FAIL div_ovf_hi got %h want 00000000", hi); end
    step();
  endtask

  task automatic test_mthi_mtlo_divzero();
    int nb; logic d;
    start = 1'b1; mdu_op = 3'd5; in_a = 32'h1234;
    step();
    n_checks++; if (hi !== 32'h1234) begin n_fail++; $display("FAIL mthi_hi got %h want 1234", hi); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mthi_busy got %h want 0", busy); end
    mdu_op = 3'd6; in_a = 32'h5678;
    step();
    n_checks++; if (lo !== 32'h5678) begin n_fail++; $display("FAIL mtlo_lo got %h want 5678", lo); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL mtlo_done got %h want 0", done); end
    mdu_op = 3'd7; in_a = 32'hDEAD; in_b = 32'd9;
    step();
    mdu_op = 3'd0;
    step();
    start = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL nop_busy got %h want 0", busy); end
    n_checks++; if ({hi, lo} !== {32'h1234, 32'h5678}) begin n_fail++; $display("FAIL nop_hilo got %h want 0000123400005678", {hi, lo}); end
    issue_and_wait(3'd3, 32'd77, 32'd0, nb, d);
    n_checks++; if (nb != 10) begin n_fail++; $display("FAIL divz_busy_cycles got %0d want 10", nb); end
    n_checks++; if (d !== 1'b1) begin n_fail++; $display("FAIL divz_done got %h want 1", d); end
    n_checks++; if ({hi, lo} !== {32'h1234, 32'h5678}) begin n_fail++; $display("FAIL divz_hilo got %h want 0000123400005678", {hi, lo}); end
    step();
  endtask

  task automatic test_stall_ignore();
    int k;
    md_use = 1'b1;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL stall_idle got %h want 0", stall); end
    start = 1'b1; mdu_op = 3'd1; in_a = 32'd3; in_b = 32'd7;
    #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL stall_start got %h want 1", stall); end
    step();
    start = 1'b0; mdu_op = 3'd0;
    k = 0;
    while (busy === 1'b1 && k < 64) begin
      n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL stall_busy_%0d got %h want 1", k, stall); end
      if (k == 1) begin start = 1'b1; mdu_op = 3'd5; in_a = 32'hAAAA; end
      if (k == 2) begin start = 1'b1; mdu_op = 3'd3; in_a = 32'd100; in_b = 32'd7; end
      if (k == 3) begin start = 1'b0; mdu_op = 3'd0; end
      k++;
      step();
    end
    n_checks++; if (k != 5) begin n_fail++; $display("FAIL stall_busy_cycles got %0d want 5", k); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL stall_after got %h want 0", stall); end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL ignore_done got %h want 1", done); end
    n_checks++; if ({hi, lo} !== {32'd0, 32'd21}) begin n_fail++; $display("FAIL ignore_hilo got %h want 0000000000000015", {hi, lo}); end
    step();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_no_div got %h want 0", busy); end
    md_use = 1'b0;
  endtask

  task automatic test_back_to_back();
    int nb; logic d;
    issue_and_wait(3'd1, 32'd2, 32'd3, nb, d);
    start = 1'b1; mdu_op = 3'd4; in_a = 32'd100; in_b = 32'd7;
    step();
    start = 1'b0; mdu_op = 3'd0; in_a = 32'd0; in_b = 32'd0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy got %h want 1", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL b2b_done_clear got %h want 0", done); end
    n_checks++; if ({hi, lo} !== {32'd0, 32'd6}) begin n_fail++; $display("FAIL b2b_first_hilo got %h want 0000000000000006", {hi, lo}); end
    nb = 0;
    while (busy === 1'b1 && nb < 64) begin
      nb++;
      step();
    end
    n_checks++; if (nb != 10) begin n_fail++; $display("FAIL b2b_busy_cycles got %0d want 10", nb); end
    n_checks++; if ({hi, lo} !== {32'd2, 32'd14}) begin n_fail++; $display("FAIL b2b_second_hilo got %h want 000000020000000e", {hi, lo}); end
    step();
  endtask

  task automatic test_reset_midop();
    logic saw_activity;
    start = 1'b1; mdu_op = 3'd3; in_a = 32'd50; in_b = 32'd3;
    step();
    start = 1'b0; mdu_op = 3'd0;
    step(); step(); step();
    reset = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got %h want 0", busy); end
    n_checks++; if ({hi, lo} !== 64'd0) begin n_fail++; $display("FAIL rst_mid_hilo got %h want 0", {hi, lo}); end
    step();
    reset = 1'b0;
    saw_activity = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (done !== 1'b0 || busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) saw_activity = 1'b1;
    end
    n_checks++; if (saw_activity !== 1'b0) begin n_fail++; $display("FAIL rst_mid_discard got %h want 0", saw_activity); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_mthi_mtlo_divzero();
    test_stall_ignore();
    test_back_to_back();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
